time_digit_scanner: RTL
=======================

# time_digit_scanner

Time-multiplexes one shared combinational binary-to-BCD converter across the hours, minutes and seconds fields of the clock and drives a 6-digit multiplexed display, one digit per scan strobe. It sits between the timekeeping counters and the display pins. It takes a tear-free snapshot of the time at each frame start, sequences the converter's input, waits for it to settle, captures the selected BCD digit and presents it with a one-hot digit select.

## Interface
- SETTLE_CYCLES, 1: clock edges between driving `bcd_value` and capturing the converter result. Legal range 1..15.
- BLANK_LEAD_ZERO, 1: when 1, a hours-tens digit of 0 is shown blanked.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- hours  in  8  binary hours, 0..99 legal.
- minutes  in  8  binary minutes, 0..99 legal.
- seconds  in  8  binary seconds, 0..99 legal.
- scan_tick  in  1  one-cycle strobe; advance to the next digit.
- bcd_value  out  8  registered value driven into the shared converter.
- bcd_tens  in  4  converter tens result.
- bcd_ones  in  4  converter ones result.
- digit_sel  out  6  one-hot active-high digit enable, bit i = digit i.
- digit_bcd  out  4  BCD code of the displayed digit.
- blank  out  1  1 = current digit dark.
- frame_start  out  1  one-cycle pulse when digit 0 becomes visible.
- overrun  out  1  sticky; a scan_tick arrived while settling.

## Operation
- Digit index order: 0 hours tens, 1 hours ones, 2 minutes tens, 3 minutes ones, 4 seconds tens, 5 seconds ones. Field = index/2. Even index takes `bcd_tens`; odd index takes `bcd_ones`.
- States: IDLE (post-reset), SETTLE, SHOW.
- IDLE/SHOW + scan_tick:
  - Index advances (5 wraps to 0).
  - `digit_sel` goes to 0 (anti-ghosting gap).
  - Settle counter loads SETTLE_CYCLES.
  - State goes to SETTLE.
  - `bcd_value` loads the new index's field from the snapshot.
- Snapshot: when the new index is 0, hours/minutes/seconds are latched into the snapshot registers on that same edge. `bcd_value` is then loaded directly from the live `hours` input. Snapshot registers do not change at any other time.
- SETTLE: the counter decrements on each edge. On the edge where the counter equals 1:
  - The selected converter nibble is latched into `digit_bcd`.
  - `digit_sel` is set one-hot for the index.
  - `blank` is updated.
  - State goes to SHOW.
  - `frame_start` pulses for one cycle if the index is 0.
- Range: if the snapshot field is >99, both digits of that field show `digit_bcd`=4'hF with `blank`=1. `digit_sel` is still driven.
- Leading zero: with BLANK_LEAD_ZERO=1, index 0 with tens=0 gives `blank`=1 and `digit_bcd`=0.
- scan_tick while in SETTLE is dropped: the index does not advance and `overrun` is set. `overrun` clears only on rst.
- scan_tick in IDLE or SHOW is never dropped.

## Timing
- Reset values: index=5, state IDLE, `bcd_value`=0, `digit_sel`=0, `digit_bcd`=0, `blank`=1, `frame_start`=0, `overrun`=0, snapshot=0. The first scan_tick therefore selects digit 0 and takes a snapshot.
- Latency: a tick sampled at edge E gives new `digit_sel`/`digit_bcd` visible after edge E+SETTLE_CYCLES. `digit_sel` is 0 for cycles E..E+SETTLE_CYCLES-1.
- Converter path: `bcd_value` is registered at E; the converter must settle within one clock period.
- Back-to-back ticks: the minimum accepted tick spacing is SETTLE_CYCLES+1 edges. A tick on the same edge as the SETTLE→SHOW transition counts as an overrun.
- rst during SETTLE or SHOW: the next state is IDLE with all reset values. No partial digit is latched and `frame_start` is not pulsed.
- Inputs changing mid-frame have no effect until the next index-0 tick.

## Test plan
- Reset, hours=12, minutes=34, seconds=56, SETTLE_CYCLES=1, ticks every 4 cycles → digits 1,2,3,4,5,6 on `digit_sel` 000001..100000. Each appears 1 edge after its tick. `frame_start` pulses with digit 0.
- hours=7, BLANK_LEAD_ZERO=1 → digit 0 has `blank`=1; digit 1 shows 7 with `blank`=0. With BLANK_LEAD_ZERO=0, digit 0 shows 0 unblanked.
- Change seconds 56→57 after digit 2 is shown → digits 4,5 still show 5,6. The next frame shows 5,7.
- minutes=150 → digits 2 and 3 show 4'hF with `blank`=1. Other digits are unaffected.
- SETTLE_CYCLES=3, a second tick 2 edges after the first → second tick ignored, `overrun`=1 and stays 1. The index advances only once.
- Assert rst one cycle into SETTLE → all outputs return to reset values. The next tick shows digit 0 of a fresh snapshot.

Source files
------------

// File: rtl/time_digit_scanner_if.sv
// Signal bundle between the time scanner, the timekeeping counters, the shared
// binary-to-BCD converter and the multiplexed display pins.
interface time_digit_scanner_if;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       scan_tick;
    logic [7:0] bcd_value;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [5:0] digit_sel;
    logic [3:0] digit_bcd;
    logic       blank;
    logic       frame_start;
    logic       overrun;

    modport slave (
        input  hours, minutes, seconds, scan_tick, bcd_tens, bcd_ones,
        output bcd_value, digit_sel, digit_bcd, blank, frame_start, overrun
    );

    modport master (
        output hours, minutes, seconds, scan_tick, bcd_tens, bcd_ones,
        input  bcd_value, digit_sel, digit_bcd, blank, frame_start, overrun
    );
endinterface

// File: rtl/time_digit_scanner.sv
// Scans a six-digit HH:MM:SS display, sharing one external binary-to-BCD
// converter across the three time fields and snapshotting the time per frame.
module time_digit_scanner #(
    parameter int unsigned SETTLE_CYCLES   = 1,
    parameter bit          BLANK_LEAD_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    time_digit_scanner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SHOW} state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [3:0] count_q, count_d;
    logic [7:0] snapHours_q, snapHours_d;
    logic [7:0] snapMinutes_q, snapMinutes_d;
    logic [7:0] snapSeconds_q, snapSeconds_d;
    logic [7:0] bcdValue_q, bcdValue_d;
    logic [5:0] digitSel_q, digitSel_d;
    logic [3:0] digitBcd_q, digitBcd_d;
    logic       blank_q, blank_d;
    logic       frameStart_q, frameStart_d;
    logic       overrun_q, overrun_d;

    logic       tickAccept;
    logic [2:0] nextIndex;
    logic [7:0] loadField;
    logic [7:0] shownField;
    logic [3:0] shownNibble;

    assign tickAccept = bus.scan_tick && (state_q != SETTLE);
    assign nextIndex  = (index_q == 3'd5) ? 3'd0 : index_q + 3'd1;

    // Field feeding the converter for the upcoming digit, and the field of the digit being captured.
    always_comb begin
        unique case (nextIndex[2:1])
            2'd0:    loadField = snapHours_q;
            2'd1:    loadField = snapMinutes_q;
            default: loadField = snapSeconds_q;
        endcase
        unique case (index_q[2:1])
            2'd0:    shownField = snapHours_q;
            2'd1:    shownField = snapMinutes_q;
            default: shownField = snapSeconds_q;
        endcase
        shownNibble = index_q[0] ? bus.bcd_ones : bus.bcd_tens;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            index_q       <= 3'd5;
            count_q       <= 4'd0;
            snapHours_q   <= 8'd0;
            snapMinutes_q <= 8'd0;
            snapSeconds_q <= 8'd0;
            bcdValue_q    <= 8'd0;
            digitSel_q    <= 6'd0;
            digitBcd_q    <= 4'd0;
            blank_q       <= 1'b1;
            frameStart_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            count_q       <= count_d;
            snapHours_q   <= snapHours_d;
            snapMinutes_q <= snapMinutes_d;
            snapSeconds_q <= snapSeconds_d;
            bcdValue_q    <= bcdValue_d;
            digitSel_q    <= digitSel_d;
            digitBcd_q    <= digitBcd_d;
            blank_q       <= blank_d;
            frameStart_q  <= frameStart_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, SHOW: if (bus.scan_tick) state_d = SETTLE;
            SETTLE:     if (count_q == 4'd1) state_d = SHOW;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        index_d       = index_q;
        count_d       = count_q;
        snapHours_d   = snapHours_q;
        snapMinutes_d = snapMinutes_q;
        snapSeconds_d = snapSeconds_q;
        bcdValue_d    = bcdValue_q;
        digitSel_d    = digitSel_q;
        digitBcd_d    = digitBcd_q;
        blank_d       = blank_q;
        frameStart_d  = 1'b0;
        overrun_d     = overrun_q;

        if (tickAccept) begin
            index_d    = nextIndex;
            count_d    = SETTLE_LOAD;
            digitSel_d = 6'd0;
            // Digit 0 starts a frame: snapshot the live time and feed live hours straight through.
            if (nextIndex == 3'd0) begin
                snapHours_d   = bus.hours;
                snapMinutes_d = bus.minutes;
                snapSeconds_d = bus.seconds;
                bcdValue_d    = bus.hours;
            end else begin
                bcdValue_d = loadField;
            end
        end else if (state_q == SETTLE) begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
                digitSel_d   = 6'(1) << index_q;
                frameStart_d = (index_q == 3'd0);
                if (shownField > 8'd99) begin
                    digitBcd_d = 4'hF;
                    blank_d    = 1'b1;
                end else if (BLANK_LEAD_ZERO && index_q == 3'd0 && bus.bcd_tens == 4'd0) begin
                    digitBcd_d = 4'd0;
                    blank_d    = 1'b1;
                end else begin
                    digitBcd_d = shownNibble;
                    blank_d    = 1'b0;
                end
            end
        end

        if (bus.scan_tick && state_q == SETTLE) overrun_d = 1'b1;
    end

    assign bus.bcd_value   = bcdValue_q;
    assign bus.digit_sel   = digitSel_q;
    assign bus.digit_bcd   = digitBcd_q;
    assign bus.blank       = blank_q;
    assign bus.frame_start = frameStart_q;
    assign bus.overrun     = overrun_q;
endmodule
